// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, PC increment and the fetch queue entry layout.
package cpu_pkg;

    localparam int unsigned INSN_W   = 32;
    localparam int unsigned PC_STEP  = 4;
    localparam int unsigned PKG_XLEN = 32;

    typedef struct packed {
        logic [PKG_XLEN-1:0] pc;
        logic [INSN_W-1:0]   instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of DEPTH entries (DEPTH a power of two). flush empties it and overrides push/pop.
module fetch_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned W     = 64,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [CW-1:0] count,
    output logic [W-1:0]  head
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Pointers are exactly AW bits wide, so the +1 wraps at DEPTH on its own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (!push && pop) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !flush && push) mem_q[wr_ptr_q] <= push_data;
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: sequential PC generation, one-cycle-latency imem requests,
// and a DEPTH-entry queue of {pc, instr} feeding IF/ID. redirect flushes and restarts fetch.
module fetch_queue_unit
    import cpu_pkg::*;
#(
    parameter  int unsigned     XLEN     = 32,
    parameter  int unsigned     DEPTH    = 4,
    parameter  logic [XLEN-1:0] RESET_PC = '0,
    localparam int unsigned     CW       = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic [INSN_W-1:0] imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INSN_W-1:0] out_instr,
    output logic [XLEN-1:0]   out_pc,
    output logic [CW-1:0]     count
);

    localparam int unsigned EW = XLEN + INSN_W;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic            inflight_q, inflight_d;
    logic [CW-1:0]   q_count;
    logic [CW-1:0]   occupancy;
    logic [EW-1:0]   head;
    logic            pop, push, issue;

    // Output handshake: an entry transfers on a cycle where out_valid && out_ready;
    // out_valid never depends on out_ready, and the head is held until it transfers.
    assign out_valid = rst & ~redirect & (q_count != '0);
    assign pop       = out_valid & out_ready;
    assign push      = inflight_q & ~redirect;

    // Every outstanding request owns a queue slot, so the queue can never overflow.
    assign occupancy = q_count + CW'(inflight_q) - CW'(pop);
    assign issue     = rst & ~redirect & (occupancy < CW'(DEPTH));

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = issue;
        if (redirect) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (issue) begin
            fetch_pc_d    = fetch_pc_q + XLEN'(PC_STEP);
            inflight_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (push),
        .push_data ({inflight_pc_q, imem_rdata}),
        .pop       (pop),
        .count     (q_count),
        .head      (head)
    );

    assign imem_req  = issue;
    assign imem_addr = fetch_pc_q;
    assign out_pc    = out_valid ? head[EW-1:INSN_W] : '0;
    assign out_instr = out_valid ? head[INSN_W-1:0] : '0;
    assign count     = q_count;

endmodule
